// File: rtl/button_gesture_decoder_pkg.sv
// Shared state encoding and default timing constants for the button gesture decoder
// and the downstream command logic that decodes the same states.
package button_gesture_decoder_pkg;

    localparam int DEF_COUNTER_WIDTH     = 16;
    localparam int DEF_LONG_PRESS_CYCLES = 50000;
    localparam int DEF_DOUBLE_GAP_CYCLES = 15000;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } gesture_state_t;

    // States in which the shared interval counter runs.
    function automatic logic is_timed(input gesture_state_t s);
        return (s == ST_PRESSED) || (s == ST_WAIT_SECOND) || (s == ST_SECOND_PRESSED);
    endfunction

endpackage

// File: rtl/button_gesture_decoder_timer.sv
// Shared interval counter: cleared on state entry, counts while enabled,
// flags the cycle in which it reaches the supplied terminal count.
module gesture_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal_count,
    output logic [WIDTH-1:0] cnt,
    output logic             terminal
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt      = r_cnt;
    assign terminal = enable && (r_cnt == terminal_count);

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button edge pulses into short press, double click and long press
// (plus a hold level), emitting exactly one registered pulse per gesture.
module button_gesture_decoder
    import button_gesture_decoder_pkg::*;
#(
    parameter int COUNTER_WIDTH     = DEF_COUNTER_WIDTH,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int DOUBLE_GAP_CYCLES = DEF_DOUBLE_GAP_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic on_button_down,
    input  logic on_button_up,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic hold_active
);

    localparam logic [COUNTER_WIDTH-1:0] LONG_TC = COUNTER_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] GAP_TC  = COUNTER_WIDTH'(DOUBLE_GAP_CYCLES - 1);

    gesture_state_t         r_state;
    gesture_state_t         w_next;
    logic                   r_short, r_double, r_long, r_hold;
    logic                   w_down, w_up, w_clear, w_enable, w_terminal;
    logic [COUNTER_WIDTH-1:0] w_tc;
    logic [COUNTER_WIDTH-1:0] w_unused_cnt;

    // Simultaneous down and up cancel each other out.
    assign w_down   = on_button_down & ~on_button_up;
    assign w_up     = on_button_up & ~on_button_down;
    assign w_tc     = (r_state == ST_WAIT_SECOND) ? GAP_TC : LONG_TC;
    assign w_enable = is_timed(r_state);
    assign w_clear  = (w_next != r_state);

    gesture_timer #(
        .WIDTH(COUNTER_WIDTH)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .clear         (w_clear),
        .enable        (w_enable),
        .terminal_count(w_tc),
        .cnt           (w_unused_cnt),
        .terminal      (w_terminal)
    );

    // NOTE: next state defaults to the current state first, so no path through this block infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:           if (w_down) w_next = ST_PRESSED;
            ST_PRESSED:        if (w_up) w_next = ST_WAIT_SECOND;
                               else if (w_terminal) w_next = ST_LONG_HELD;
            ST_LONG_HELD:      if (w_up) w_next = ST_IDLE;
            ST_WAIT_SECOND:    if (w_down) w_next = ST_SECOND_PRESSED;
                               else if (w_terminal) w_next = ST_IDLE;
            ST_SECOND_PRESSED: if (w_up) w_next = ST_IDLE;
                               else if (w_terminal) w_next = ST_LONG_HELD;
            default:           w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_short  <= (r_state == ST_WAIT_SECOND) && (w_next == ST_IDLE);
            r_double <= (r_state == ST_SECOND_PRESSED) && (w_next == ST_IDLE);
            r_long   <= (r_state != ST_LONG_HELD) && (w_next == ST_LONG_HELD);
            r_hold   <= (w_next == ST_LONG_HELD);
        end
    end

    assign short_press  = r_short;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign hold_active  = r_hold;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench for button_gesture_decoder: directed gestures push expected output
// events with their cycle; a monitor pops and compares whenever an output fires.
module tb_button_gesture_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic on_button_down = 1'b0;
    logic on_button_up = 1'b0;
    logic short_press, double_click, long_press, hold_active;

    button_gesture_decoder #(
        .COUNTER_WIDTH    (16),
        .LONG_PRESS_CYCLES(LONG),
        .DOUBLE_GAP_CYCLES(GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .on_button_down(on_button_down),
        .on_button_up  (on_button_up),
        .short_press   (short_press),
        .double_click  (double_click),
        .long_press    (long_press),
        .hold_active   (hold_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_SHORT = 0, EV_DOUBLE = 1, EV_LONG = 2, EV_HOLD_ON = 3, EV_HOLD_OFF = 4} ev_kind_t;
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t   exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    base = 0;
    string ev_name[5] = '{"short_press", "double_click", "long_press", "hold_rise", "hold_fall"};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output event is matched against the head of the scoreboard.
    logic prev_hold = 1'b0;
    always @(negedge clk) begin : monitor
        logic [4:0] fired;
        int         npulse;
        ev_t        e;
        fired  = {(prev_hold === 1'b1) && (hold_active === 1'b0),
                  (prev_hold === 1'b0) && (hold_active === 1'b1),
                  long_press === 1'b1, double_click === 1'b1, short_press === 1'b1};
        npulse = int'(fired[0]) + int'(fired[1]) + int'(fired[2]);
        if (!reset) begin
            if (npulse > 0) check("pulse_exclusive", npulse, 1);
            for (int i = 0; i < 5; i++) begin
                if (fired[i]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_%s: got event at cycle %0d, required none", ev_name[i], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check({ev_name[i], "_kind"}, i, e.kind);
                        check({ev_name[i], "_cycle"}, cyc, e.cyc);
                    end
                end
            end
        end
        prev_hold = hold_active;
    end

    function automatic logic [63:0] b(input int t);
        logic [63:0] v;
        v    = '0;
        v[t] = 1'b1;
        return v;
    endfunction

    task automatic drive(input logic d, input logic u, input logic r);
        @(posedge clk);
        #1;
        on_button_down = d;
        on_button_up   = u;
        reset          = r;
    endtask

    task automatic start();
        base = cyc + 1;
    endtask

    task automatic expect_ev(input ev_kind_t k, input int rel);
        ev_t e;
        e.kind = int'(k);
        e.cyc  = base + rel;
        exp_q.push_back(e);
    endtask

    task automatic play(input int len, input logic [63:0] dv, input logic [63:0] uv, input logic [63:0] rv);
        for (int i = 0; i < len; i++) drive(dv[i], uv[i], rv[i]);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle(input string name);
        play(12, '0, '0, '0);
        check({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int kind, h, h1, g, h2, up2;

        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("reset_short", int'(short_press), 0);
        check("reset_double", int'(double_click), 0);
        check("reset_long", int'(long_press), 0);
        check("reset_hold", int'(hold_active), 0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        start(); expect_ev(EV_SHORT, 8);
        play(4, b(0), b(3), '0); settle("short");

        start(); expect_ev(EV_DOUBLE, 7);
        play(7, b(0) | b(4), b(2) | b(6), '0); settle("double");

        start(); expect_ev(EV_LONG, 9); expect_ev(EV_HOLD_ON, 9); expect_ev(EV_HOLD_OFF, 21);
        play(21, b(0), b(20), '0); settle("long");

        start(); expect_ev(EV_SHORT, 12);
        play(8, b(0), b(7), '0); settle("up_t7");

        start(); expect_ev(EV_SHORT, 13);
        play(9, b(0), b(8), '0); settle("up_at_long_tc");

        start(); expect_ev(EV_DOUBLE, 9);
        play(9, b(0) | b(6), b(2) | b(8), '0); settle("gap_race");

        start(); expect_ev(EV_LONG, 13); expect_ev(EV_HOLD_ON, 13); expect_ev(EV_HOLD_OFF, 16);
        play(16, b(0) | b(4), b(2) | b(15), '0); settle("second_long");

        start();
        play(21, b(0), b(2) | b(5), b(3)); settle("reset_mid");

        start();
        play(12, b(0), b(0), '0); settle("both_idle");

        start(); expect_ev(EV_SHORT, 10);
        play(6, b(0) | b(3), b(3) | b(5), '0); settle("both_pressed");

        start(); expect_ev(EV_SHORT, 9);
        play(5, b(0) | b(2), b(4), '0); settle("down_in_pressed");

        for (int n = 0; n < 12; n++) begin
            kind = int'($urandom_range(0, 2));
            start();
            if (kind == 0) begin
                h = int'($urandom_range(1, 7));
                expect_ev(EV_SHORT, h + 5);
                play(h + 1, b(0), b(h), '0);
            end else if (kind == 1) begin
                h1  = int'($urandom_range(1, 7));
                g   = int'($urandom_range(1, GAP));
                h2  = int'($urandom_range(1, 7));
                up2 = h1 + g + h2;
                expect_ev(EV_DOUBLE, up2 + 1);
                play(up2 + 1, b(0) | b(h1 + g), b(h1) | b(up2), '0);
            end else begin
                h = int'($urandom_range(LONG + 1, 15));
                expect_ev(EV_LONG, LONG + 1); expect_ev(EV_HOLD_ON, LONG + 1); expect_ev(EV_HOLD_OFF, h + 1);
                play(h + 1, b(0), b(h), '0);
            end
            settle("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
